// File: rtl/uart_host_sequencer.sv
// -----------------------------------------------------------------------------
// uart_host_sequencer
//
// Purpose:
//   Bus master that stands in for a CPU on the UART peripheral's register
//   interface. After cfg_start it programs the UART (disable, baud divisor,
//   enable, interrupt mask). It then arbitrates two byte requesters into the
//   UART transmit FIFO and kicks transmission on flush or when the FIFO fills.
//
// Optional feature (compile-time macro UART_SEQ_POLL_TIMEOUT_EN):
//   When defined, consecutive "FIFO full" status reads are counted. After
//   MAX_POLL of them, err sets (sticky until RST), the pending grant is
//   dropped without ack, and the FIFO is drained with a kick. When undefined,
//   POLL repeats forever and err is tied low.
//
// Ports:
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   cfg_start          pulse, starts configuration from IDLE only
//   cfg_done           high in READY and in every transmit-phase state
//   req_a/req_b        requester wants to send one byte (held until ack)
//   data_a/data_b      byte of that requester, stable while req is high
//   ack_a/ack_b        one-cycle pulse during the data-register write strobe
//   flush              level, request a kick when fifo_count is nonzero
//   bus_addr           0 status, 1 int mask, 2 data, 3 baud
//   bus_ncs/no/nw      active-low chip select, read enable, write enable
//   bus_dout, bus_oe   write data and its drive enable (writes only)
//   bus_din            DATA as seen by the sequencer (status reads)
//   fifo_count         bytes written since the last kick, 0..FIFO_DEPTH
//   busy               high while the FSM is in any bus-cycle state
//   err                sticky poll-timeout flag (0 without the macro)
//   dbg_state          current FSM state, for observation only
//
// Requester handshake: a requester raises req with its byte on data and
// holds both steady until it sees ack. ack is high for exactly the one clock
// in which the data-register write strobe (bus_nw low) is on the bus; the
// byte is accepted at the rising edge that ends that clock, and the
// requester may drop req or present a new byte from that edge on. Dropping
// req before it has been granted withdraws the request with no ack.
// -----------------------------------------------------------------------------
module uart_host_sequencer #(
  parameter logic [7:0] BAUD_DIV   = 8'd16,
  parameter logic [7:0] INT_MASK   = 8'h00,
  parameter int         FIFO_DEPTH = 16,
  parameter int         MAX_POLL   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cfg_start,
  output logic       cfg_done,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  input  logic       flush,
  output logic [1:0] bus_addr,
  output logic       bus_ncs,
  output logic       bus_no,
  output logic       bus_nw,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din,
  output logic [4:0] fifo_count,
  output logic       busy,
  output logic       err,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_DIS   = 4'd1,
    S_W_BAUD  = 4'd2,
    S_W_EN    = 4'd3,
    S_W_INT   = 4'd4,
    S_READY   = 4'd5,
    S_POLL    = 4'd6,
    S_W_DATA  = 4'd7,
    S_W_KICK  = 4'd8,
    S_W_REARM = 4'd9
  } state_t;

  // Phase within a bus cycle. Writes use SETUP, STROBE, GAP; reads use
  // SETUP and STROBE as their first and second clock.
  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_STROBE = 2'd1;
  localparam logic [1:0] PH_GAP    = 2'd2;

  localparam logic [4:0] FULL_COUNT = 5'(FIFO_DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ph;
  logic [1:0]  w_ph_nxt;

  logic        r_gnt_b;       // granted requester: 0 = A, 1 = B
  logic [7:0]  r_data;        // byte latched at POLL entry
  logic        r_ptr_b;       // preferred requester on a tie: 0 = A, 1 = B
  logic [4:0]  r_fifo_count;

  logic        w_kick_pend;
  logic        w_grant;
  logic        w_grant_b;
  logic        w_full_read;   // second clock of a read that saw FIFO full
  logic        w_byte_done;   // data-register strobe clock
  logic        w_kick_done;   // last clock of the rearm write
  logic        w_timeout;

  logic        w_is_write;
  logic [1:0]  w_wr_addr;
  logic [7:0]  w_wr_data;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ph    <= PH_SETUP;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_grant     = 1'b0;
    w_grant_b   = 1'b0;
    w_full_read = 1'b0;
    w_kick_pend = (r_fifo_count == FULL_COUNT) ||
                  (flush && (r_fifo_count != 5'd0));

    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_state_nxt = S_W_DIS;
          w_ph_nxt    = PH_SETUP;
        end
      end

      S_READY: begin
        // A pending kick always wins over a new grant.
        if (w_kick_pend) begin
          w_state_nxt = S_W_KICK;
          w_ph_nxt    = PH_SETUP;
        end else if (req_a || req_b) begin
          w_grant     = 1'b1;
          w_grant_b   = req_b && (!req_a || r_ptr_b);
          w_state_nxt = S_POLL;
          w_ph_nxt    = PH_SETUP;
        end
      end

      S_POLL: begin
        if (r_ph == PH_SETUP) begin
          w_ph_nxt = PH_STROBE;
        end else if (bus_din[2]) begin
          w_full_read = 1'b1;
          w_ph_nxt    = PH_SETUP;
          if (w_timeout) begin
            w_state_nxt = S_W_KICK;
          end
        end else begin
          w_state_nxt = S_W_DATA;
          w_ph_nxt    = PH_SETUP;
        end
      end

      default: begin
        // All write states: SETUP -> STROBE -> GAP -> successor.
        if (r_ph != PH_GAP) begin
          w_ph_nxt = r_ph + 2'd1;
        end else begin
          w_ph_nxt = PH_SETUP;
          case (r_state)
            S_W_DIS:   w_state_nxt = S_W_BAUD;
            S_W_BAUD:  w_state_nxt = S_W_EN;
            S_W_EN:    w_state_nxt = S_W_INT;
            S_W_KICK:  w_state_nxt = S_W_REARM;
            default:   w_state_nxt = S_READY;   // W_INT, W_DATA, W_REARM
          endcase
        end
      end
    endcase
  end

  assign w_byte_done = (r_state == S_W_DATA)  && (r_ph == PH_STROBE);
  assign w_kick_done = (r_state == S_W_REARM) && (r_ph == PH_GAP);

  // ---------------------------------------------------------------------------
  // Datapath: grant latch, round-robin pointer, byte counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gnt_b      <= 1'b0;
      r_data       <= 8'h00;
      r_ptr_b      <= 1'b0;
      r_fifo_count <= 5'd0;
    end else begin
      if (w_grant) begin
        r_gnt_b <= w_grant_b;
        r_data  <= w_grant_b ? data_b : data_a;
      end
      if (w_byte_done) begin
        // The requester just served loses the next tie.
        r_ptr_b <= !r_gnt_b;
        if (r_fifo_count != FULL_COUNT) begin
          r_fifo_count <= r_fifo_count + 5'd1;
        end
      end else if (w_kick_done) begin
        r_fifo_count <= 5'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional poll timeout
  // ---------------------------------------------------------------------------
`ifdef UART_SEQ_POLL_TIMEOUT_EN
  localparam int PCW = $clog2(MAX_POLL + 1);

  logic [PCW-1:0] r_poll_cnt;
  logic           r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_poll_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_poll_cnt <= '0;
      end else if (w_full_read) begin
        r_poll_cnt <= r_poll_cnt + PCW'(1);
      end
      if (w_full_read && w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // True while the read now completing is the MAX_POLL-th full one.
  assign w_timeout = (r_poll_cnt == PCW'(MAX_POLL - 1));
  assign err       = r_err;
`else
  logic w_unused_poll;
  assign w_timeout     = 1'b0;
  assign err           = 1'b0;
  assign w_unused_poll = w_full_read ^ (MAX_POLL != 0);
`endif

  // ---------------------------------------------------------------------------
  // Bus outputs, decoded from the registered state so that an asynchronous
  // reset releases every strobe immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_is_write = 1'b1;
    w_wr_addr  = 2'd0;
    w_wr_data  = 8'h00;
    case (r_state)
      S_W_DIS:   begin w_wr_addr = 2'd0; w_wr_data = 8'h00;    end
      S_W_BAUD:  begin w_wr_addr = 2'd3; w_wr_data = BAUD_DIV; end
      S_W_EN:    begin w_wr_addr = 2'd0; w_wr_data = 8'h01;    end
      S_W_INT:   begin w_wr_addr = 2'd1; w_wr_data = INT_MASK; end
      S_W_DATA:  begin w_wr_addr = 2'd2; w_wr_data = r_data;   end
      S_W_KICK:  begin w_wr_addr = 2'd0; w_wr_data = 8'h03;    end
      S_W_REARM: begin w_wr_addr = 2'd0; w_wr_data = 8'h01;    end
      default:   w_is_write = 1'b0;
    endcase
  end

  always_comb begin
    bus_ncs  = 1'b1;
    bus_no   = 1'b1;
    bus_nw   = 1'b1;
    bus_oe   = 1'b0;
    bus_addr = 2'd0;
    bus_dout = 8'h00;
    if (w_is_write && (r_ph != PH_GAP)) begin
      bus_ncs  = 1'b0;
      bus_oe   = 1'b1;
      bus_addr = w_wr_addr;
      bus_dout = w_wr_data;
      bus_nw   = (r_ph != PH_STROBE);
    end else if (r_state == S_POLL) begin
      bus_ncs  = 1'b0;
      bus_no   = 1'b0;
      bus_addr = 2'd0;
    end
  end

  // Only bit 2 (FIFO full) of the status register matters here.
  logic w_unused_din;
  assign w_unused_din = ^{bus_din[7:3], bus_din[1:0]};

  assign ack_a      = w_byte_done && !r_gnt_b;
  assign ack_b      = w_byte_done &&  r_gnt_b;
  assign fifo_count = r_fifo_count;
  assign busy       = (r_state != S_IDLE) && (r_state != S_READY);
  assign cfg_done   = (r_state == S_READY)  || (r_state == S_POLL)   ||
                      (r_state == S_W_DATA) || (r_state == S_W_KICK) ||
                      (r_state == S_W_REARM);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_host_sequencer
//
// Directed plus randomized bench. A bus monitor collects every completed
// register write as {addr, data}; a reference model of the sequencer's rules
// (bytes since last kick, round-robin preference, kick on full or flush)
// builds the expected write list, and the two lists are compared per step.
// -----------------------------------------------------------------------------
module tb_uart_host_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cfg_start;
  logic       cfg_done;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b;
  logic       flush;
  logic [1:0] bus_addr;
  logic       bus_ncs, bus_no, bus_nw;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic [7:0] bus_din;
  logic [4:0] fifo_count;
  logic       busy;
  logic       err;
  logic [3:0] dbg_state;

  uart_host_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .cfg_start  (cfg_start),
    .cfg_done   (cfg_done),
    .req_a      (req_a),
    .req_b      (req_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .flush      (flush),
    .bus_addr   (bus_addr),
    .bus_ncs    (bus_ncs),
    .bus_no     (bus_no),
    .bus_nw     (bus_nw),
    .bus_dout   (bus_dout),
    .bus_oe     (bus_oe),
    .bus_din    (bus_din),
    .fifo_count (fifo_count),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // UART status model and scoreboard state
  // ---------------------------------------------------------------------------
  logic       uart_full;
  logic [7:0] din_noise;
  assign bus_din = {din_noise[7:3], uart_full, din_noise[1:0]};

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          errors = 0;
  int          checks = 0;

  int   m_cnt;      // bytes written since last kick
  logic m_pref_b;   // requester that wins the next tie

  int   rd_cycles;
  int   max_count;
  logic prev_nw_low, prev_ack_a, prev_ack_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic [1:0] a, input logic [7:0] d);
    return {22'd0, a, d};
  endfunction

  function automatic void model_kick();
    exp_q.push_back(wr(2'd0, 8'h03));
    exp_q.push_back(wr(2'd0, 8'h01));
    m_cnt = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] d);
    exp_q.push_back(wr(2'd2, d));
    m_cnt = m_cnt + 1;
    if (m_cnt == 16) model_kick();
  endfunction

  // ---------------------------------------------------------------------------
  // Bus monitor
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (RST) begin
      prev_nw_low = 1'b0;
      prev_ack_a  = 1'b0;
      prev_ack_b  = 1'b0;
    end else begin
      if (!bus_nw) begin
        chk("strobe_width", 32'(prev_nw_low), 32'd0);
        chk("strobe_ctl", 32'({bus_ncs, bus_oe, bus_no}), 32'b011);
        obs_q.push_back({22'd0, bus_addr, bus_dout});
      end
      if (!bus_no) begin
        rd_cycles++;
        chk("read_ctl", 32'({bus_ncs, bus_oe, bus_addr, bus_nw}), 32'b00001);
      end
      if (ack_a || ack_b) begin
        chk("ack_strobe", 32'({bus_nw, bus_addr}), 32'b010);
        chk("ack_single", 32'({prev_ack_a & ack_a, prev_ack_b & ack_b, ack_a & ack_b}), 32'd0);
      end
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      prev_nw_low = !bus_nw;
      prev_ack_a  = ack_a;
      prev_ack_b  = ack_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_writes(input string tag);
    int n;
    logic [31:0] e, o;
    n = 0;
    while ((obs_q.size() < exp_q.size()) && (n < 400)) begin
      @(negedge CLK);
      n++;
    end
    repeat (8) @(negedge CLK);
    chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      chk(tag, o, e);
    end
    obs_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cfg_start = 1'b0; req_a = 1'b0; req_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00; flush = 1'b0;
    uart_full = 1'b0; din_noise = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    m_cnt = 0;
    m_pref_b = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic configure();
    int t;
    exp_q.push_back(wr(2'd0, 8'h00));
    exp_q.push_back(wr(2'd3, 8'h10));
    exp_q.push_back(wr(2'd0, 8'h01));
    exp_q.push_back(wr(2'd1, 8'h00));
    cfg_start = 1'b1;
    @(negedge CLK);
    cfg_start = 1'b0;
    t = 0;
    while (!cfg_done && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("cfg_done", 32'(cfg_done), 32'd1);
    check_writes("cfg");
  endtask

  // Raise the requests in mask, serve until each has been acked once.
  task automatic serve(input logic [1:0] mask, input logic [7:0] da, input logic [7:0] db);
    logic pend_a, pend_b, exp_b;
    int t;
    pend_a = mask[0];
    pend_b = mask[1];
    data_a = da;
    data_b = db;
    req_a  = pend_a;
    req_b  = pend_b;
    t = 0;
    while ((pend_a || pend_b) && t < 1000) begin
      @(negedge CLK);
      t++;
      if (ack_a || ack_b) begin
        exp_b = pend_b && (!pend_a || m_pref_b);
        chk("rr_winner", 32'(ack_b), 32'(exp_b));
        model_byte(ack_b ? db : da);
        m_pref_b = !ack_b;
        if (ack_a) begin pend_a = 1'b0; req_a = 1'b0; end
        if (ack_b) begin pend_b = 1'b0; req_b = 1'b0; end
      end
    end
    chk("serve_done", 32'({pend_a, pend_b}), 32'd0);
    req_a = 1'b0;
    req_b = 1'b0;
    check_writes("serve");
  endtask

  // Both requesters keep req high across n acks.
  task automatic held_both(input int n);
    int got, t;
    req_a = 1'b1; req_b = 1'b1;
    data_a = 8'hAA; data_b = 8'h55;
    got = 0; t = 0;
    while (got < n && t < 2000) begin
      @(negedge CLK);
      t++;
      if (ack_a || ack_b) begin
        chk("arb_winner", 32'(ack_b), 32'(m_pref_b));
        model_byte(ack_b ? 8'h55 : 8'hAA);
        m_pref_b = !ack_b;
        got++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("arb_acks", 32'(got), 32'(n));
    check_writes("arb");
  endtask

  task automatic do_flush();
    if (m_cnt != 0) model_kick();
    flush = 1'b1;
    check_writes("flush");
    chk("flush_count", 32'(fifo_count), 32'd0);
    flush = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int busy_seen, t, acked;
    rd_cycles = 0;
    max_count = 0;

    // Reset values
    do_reset();
    RST = 1'b1;
    #1;
    chk("rst_strobes", 32'({bus_ncs, bus_no, bus_nw, bus_oe}), 32'b1110);
    chk("rst_addr_dout", 32'({bus_addr, bus_dout}), 32'd0);
    chk("rst_flags", 32'({cfg_done, ack_a, ack_b, busy, err}), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);   // IDLE encodes as 0
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_quiet", 32'({busy, cfg_done, bus_ncs}), 32'b001);

    // Configuration sequence
    configure();

    // cfg_start outside IDLE is ignored
    cfg_start = 1'b1;
    @(negedge CLK);
    cfg_start = 1'b0;
    repeat (10) @(negedge CLK);
    chk("cfg_restart_ignored", 32'(obs_q.size()), 32'd0);
    chk("cfg_still_done", 32'(cfg_done), 32'd1);

    // Single byte: one status read, one data write
    rd_cycles = 0;
    serve(2'b01, 8'h41, 8'h00);
    chk("single_reads", 32'(rd_cycles), 32'd2);
    chk("single_count", 32'(fifo_count), 32'd1);

    // Arbitration with both held high
    held_both(4);
    chk("arb_count", 32'(fifo_count), 32'(m_cnt));

    // Flush with nonzero count, then three bytes and flush again
    do_flush();
    serve(2'b01, 8'h11, 8'h00);
    serve(2'b10, 8'h00, 8'h22);
    serve(2'b01, 8'h33, 8'h00);
    chk("pre_flush_count", 32'(fifo_count), 32'd3);
    do_flush();

    // Flush with zero count: no bus activity
    obs_q.delete();
    flush = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (busy) busy_seen++;
    end
    flush = 1'b0;
    chk("flush_empty_busy", 32'(busy_seen), 32'd0);
    chk("flush_empty_writes", 32'(obs_q.size()), 32'd0);

    // Auto-kick after 16 bytes
    max_count = 0;
    for (int i = 0; i < 17; i++) begin
      serve(2'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));
    end
    chk("autokick_max", 32'(max_count), 32'd16);
    chk("autokick_count", 32'(fifo_count), 32'd1);

    // Randomized mix of single, contended and flush operations
    for (int i = 0; i < 40; i++) begin
      din_noise = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        do_flush();
      end else begin
        serve(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
      end
    end
    chk("random_count", 32'(fifo_count), 32'(m_cnt));

    // FIFO full: POLL keeps reading
    obs_q.delete();
    uart_full = 1'b1;
    rd_cycles = 0;
    acked = 0;
    data_a = 8'h5A;
    req_a = 1'b1;
`ifdef UART_SEQ_POLL_TIMEOUT_EN
    t = 0;
    while (!err && t < 200) begin
      @(negedge CLK);
      if (ack_a || ack_b) acked++;
      t++;
    end
    req_a = 1'b0;
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_reads", 32'(rd_cycles), 32'd16);
    chk("timeout_no_ack", 32'(acked), 32'd0);
    model_kick();
    check_writes("timeout_kick");
    chk("timeout_count", 32'(fifo_count), 32'd0);
    chk("timeout_sticky", 32'(err), 32'd1);
    uart_full = 1'b0;
`else
    repeat (40) begin
      @(negedge CLK);
      if (ack_a || ack_b) acked++;
    end
    chk("full_no_ack", 32'(acked), 32'd0);
    chk("full_polling", 32'(rd_cycles >= 30), 32'd1);
    chk("full_no_write", 32'(obs_q.size()), 32'd0);
    chk("full_err_low", 32'(err), 32'd0);
    uart_full = 1'b0;
    serve(2'b01, 8'h5A, 8'h00);
`endif

    // Reset asserted in the middle of a data strobe
    req_b = 1'b1;
    data_b = 8'hC3;
    t = 0;
    while (bus_nw && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("midrst_reached_strobe", 32'(bus_nw), 32'd0);
    RST = 1'b1;
    #1;
    chk("midrst_nw", 32'({bus_nw, bus_ncs, bus_oe}), 32'b110);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    chk("midrst_flags", 32'({ack_b, busy, cfg_done, err}), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    req_b = 1'b0;
    do_reset();

    // Full reconfiguration after reset, then one byte
    configure();
    serve(2'b10, 8'h00, 8'h7E);
    chk("post_rst_count", 32'(fifo_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_host_sequencer.md
Name: uart_host_sequencer

Overview:
- Bus-master controller that drives the UART peripheral's CPU-side register interface (ADDR/NCS/NO/NW/DATA) in place of a CPU.
- On start, runs the configuration sequence: disable, baud divisor, enable, interrupt mask.
- Then arbitrates two byte-producing requesters into the transmit FIFO and kicks transmission on flush or when the FIFO fills.
- Sits beside the UART in the top level; the top level wires bus_dout/bus_oe to a tristate onto DATA.

Parameters:
- BAUD_DIV, 8'd16, divisor written to register 3 during configuration.
- INT_MASK, 8'h00, value written to register 1 during configuration.
- FIFO_DEPTH, 16, bytes the transmit FIFO holds; auto-kick threshold.
- MAX_POLL, 8, status reads allowed while FIFO-full before error (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- cfg_start  in  1  pulse; begins configuration from IDLE; ignored elsewhere.
- cfg_done  out  1  high while in READY or any transmit-phase state.
- req_a / req_b  in  1  requester wants to send one byte; held until ack.
- data_a / data_b  in  8  byte from that requester; stable while req is high.
- ack_a / ack_b  out  1  one-cycle pulse on the cycle the byte's data-register write strobe completes.
- flush  in  1  level; request a transmit kick when the FIFO byte count is nonzero.
- bus_addr  out  2  register address: 0 status, 1 int mask, 2 data, 3 baud.
- bus_ncs, bus_no, bus_nw  out  1  active-low chip select, read enable, write enable.
- bus_dout  out  8  write data.
- bus_oe  out  1  drive DATA; high only during write cycles.
- bus_din  in  8  DATA as seen by the sequencer, for status reads.
- fifo_count  out  5  bytes written since last kick, 0..FIFO_DEPTH.
- busy  out  1  high whenever a bus cycle is in progress.
- err  out  1  sticky poll-timeout flag (optional feature only, else tied 0).

Behaviour:
- Reset values:
  - bus_ncs, bus_no, bus_nw = 1.
  - bus_oe = 0; bus_addr = 0; bus_dout = 0.
  - cfg_done, ack_a, ack_b, busy, err = 0.
  - fifo_count = 0; state = IDLE; round-robin pointer = A.
  - Reset mid-cycle returns all bus strobes high on assertion, with no completing strobe.
- Write cycle, 2 clocks:
  - SETUP: ncs=0, addr/dout valid, oe=1, nw=1.
  - STROBE: nw=0.
  - The next cycle deasserts everything.
- Read cycle, 2 clocks:
  - ncs=0, no=0 on both cycles; bus_din is sampled at the end of the second cycle.
  - oe=0 throughout.
- No idle gap between cycles is required except a forced 1-clock gap after any STROBE.
- Configuration states, in order:
  - IDLE -(cfg_start)-> W_DIS: status<=8'h00.
  - W_BAUD: reg3<=BAUD_DIV (only legal while disabled).
  - W_EN: status<=8'h01.
  - W_INT: reg1<=INT_MASK (only legal while enabled).
  - READY.
- READY arbitration and kicks:
  - Priority order: pending kick > grant.
  - A kick is pending when fifo_count==FIFO_DEPTH, or when flush=1 and fifo_count!=0.
  - Otherwise, if any req is high, grant round-robin. When both are high, the requester not granted last wins. The pointer updates only on ack.
- Grant: POLL reads status.
  - If bit2 (FIFO full) = 1, re-POLL.
  - Else W_DATA writes reg2 <= granted data, pulses ack, fifo_count+1, returns to READY.
- Kick: W_KICK writes status<=8'h03, then W_REARM writes status<=8'h01, then fifo_count<=0 and return to READY.
- A requester dropping req before grant is legal and not acknowledged. Once granted, the byte is latched at POLL entry.
- cfg_start while not IDLE is ignored. There is no reconfiguration without RST.
- fifo_count saturates at FIFO_DEPTH and never wraps; auto-kick preempts any grant at the full count.

Optional Feature:
- Macro: UART_SEQ_POLL_TIMEOUT_EN.
- Defined:
  - A poll counter counts consecutive full-status reads.
  - On reaching MAX_POLL, err sets (sticky until RST), the grant is abandoned without ack, and the state goes to W_KICK to drain the FIFO.
- Undefined: POLL repeats indefinitely; err is tied 0.

Test Plan:
- Configuration: RST, then cfg_start pulse -> writes in order (addr0,8'h00),(addr3,8'h10),(addr0,8'h01),(addr1,8'h00), each nw low exactly 1 clock; then cfg_done=1.
- Single byte: req_a with data_a=8'h41 and status bit2=0 -> one read of addr0, then write addr2=8'h41, ack_a one cycle, fifo_count=1.
- Arbitration: req_a and req_b held high with 8'hAA/8'h55 -> data writes alternate AA,55,AA,55; no requester acked twice in a row.
- Flush: fifo_count=3 and flush=1 -> writes addr0=8'h03 then addr0=8'h01, then fifo_count=0. With fifo_count=0, flush produces no bus activity.
- Auto-kick: 16 consecutive bytes -> kick sequence issued before the 17th data write; fifo_count never exceeds 16.
- Full/timeout: bus_din bit2 held 1 -> POLL repeats. With UART_SEQ_POLL_TIMEOUT_EN, after 8 reads err=1, no ack, kick issued. Assert RST mid-strobe -> bus_nw=1 immediately and state IDLE.
